// File: rtl/alu_issue_ctrl.sv
// Issue/retire stage around a combinational ALU: registers operands, captures result and flags.
// Optional accumulator chaining is built when ALU_ISSUE_ACC_EN is defined.
module alu_issue_ctrl #(
    parameter int W       = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [W-1:0]       cmd_a,
    input  logic [W-1:0]       cmd_b,
    input  logic               cmd_use_acc,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [2:0]         alu_op,
    input  logic [W-1:0]       alu_y,
    input  logic               alu_zero,
    input  logic               alu_negative,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_y,
    output logic [3:0]         res_flags,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       alu_a_q, alu_a_d;
    logic [W-1:0]       alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [W-1:0]       res_y_q, res_y_d;
    logic [3:0]         res_flags_q, res_flags_d;
    logic               res_valid_q, res_valid_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;
    logic [W-1:0]       a_src;

`ifdef ALU_ISSUE_ACC_EN
    logic [W-1:0]       acc_q, acc_d;
    assign a_src = cmd_use_acc ? acc_q : cmd_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign a_src          = cmd_a;
`endif

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_y_d     = res_y_q;
        res_flags_d = res_flags_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
`ifdef ALU_ISSUE_ACC_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = a_src;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // ALU has had a full cycle to settle on the registered operands.
                res_y_d     = alu_y;
                res_flags_d = {alu_zero, alu_negative, alu_carry, alu_overflow};
                res_valid_d = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
                acc_d       = alu_y;
`endif
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + COUNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_y_q     <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
            op_count_q  <= '0;
`ifdef ALU_ISSUE_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_y_q     <= res_y_d;
            res_flags_q <= res_flags_d;
            res_valid_q <= res_valid_d;
            op_count_q  <= op_count_d;
`ifdef ALU_ISSUE_ACC_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_flags = res_flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, directed cases, then random transactions
// against a transaction-level model. Honors ALU_ISSUE_ACC_EN.
module tb_alu_issue_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef ALU_ISSUE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_use_acc;
    logic [2:0]    cmd_op, alu_op;
    logic [W-1:0]  cmd_a, cmd_b, alu_a, alu_b, alu_y, res_y;
    logic          alu_zero, alu_negative, alu_carry, alu_overflow;
    logic          res_valid, res_ready;
    logic [3:0]    res_flags;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: accumulator contents and retired count
    logic [W-1:0]  m_acc;
    int            m_count;
    logic [W-1:0]  last_alu_a, last_y;
    logic [3:0]    last_flags;

    alu_issue_ctrl #(.W(W), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_flags(res_flags), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Returns {zero, negative, carry, overflow, y}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] wide;
        logic [7:0] y;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a ^ b;
            3'd3: begin
                wide = {1'b0, a} + {1'b0, b};
                y = wide[7:0];
                c = wide[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            3'd4: begin
                y = a - b;
                c = (a >= b);
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            3'd5: begin y = {a[6:0], 1'b0}; c = a[7]; end
            3'd6: begin y = {1'b0, a[7:1]}; c = a[0]; end
            default: y = a;
        endcase
        return {(y == 8'h00), y[7], c, v, y};
    endfunction

    always_comb {alu_zero, alu_negative, alu_carry, alu_overflow, alu_y} = alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 10) begin
            step();
            n++;
        end
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    endtask

    // One complete transaction; hold = cycles res_ready stays low in DONE.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic use_acc, input int hold);
        logic [7:0]  ea;
        logic [11:0] r;
        wait_ready();
        ea = (ACC_EN && use_acc) ? m_acc : a;
        r  = alu_fn(ea, b, op);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        step();
        // EXEC: scramble cmd_* to show they are ignored; res_ready here is ignored too
        cmd_valid   = 1'($urandom);
        cmd_op      = 3'($urandom);
        cmd_a       = 8'($urandom);
        cmd_b       = 8'($urandom);
        cmd_use_acc = 1'($urandom);
        res_ready   = 1'($urandom);
        check("exec_alu_a", 32'(alu_a), 32'(ea));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_op", 32'(alu_op), 32'(op));
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_res_valid", 32'(res_valid), 32'd0);
        last_alu_a = alu_a;
        step();
        for (int i = 0; i <= hold; i++) begin
            check("done_res_valid", 32'(res_valid), 32'd1);
            check("done_res_y", 32'(res_y), 32'(r[7:0]));
            check("done_res_flags", 32'(res_flags), 32'(r[11:8]));
            check("done_cmd_ready", 32'(cmd_ready), 32'd0);
            check("done_op_count", 32'(op_count), 32'(m_count % (1 << CW)));
            res_ready = (i == hold);
            cmd_valid = 1'($urandom);
            step();
        end
        cmd_valid  = 1'b0;
        last_y     = r[7:0];
        last_flags = r[11:8];
        m_count++;
        if (ACC_EN) m_acc = r[7:0];
        check("ret_res_valid", 32'(res_valid), 32'd0);
        check("ret_cmd_ready", 32'(cmd_ready), 32'd1);
        check("ret_op_count", 32'(op_count), 32'(m_count % (1 << CW)));
        res_ready = 1'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_y"}, 32'(res_y), 32'd0);
        check({tag, "_res_flags"}, 32'(res_flags), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
        res_ready = 1'b0;
        m_acc = '0;
        m_count = 0;
        repeat (2) step();
        check_reset_values("rst");
        @(negedge clk) rst = 1'b0;
        step();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // ADD overflow
        issue(3'd3, 8'h7F, 8'h01, 1'b0, 0);
        check("add_y", 32'(last_y), 32'h80);
        check("add_flags", 32'(last_flags), 32'b0101);
        check("add_count", 32'(op_count), 32'd1);

        // Accumulator chain
        issue(3'd3, 8'h11, 8'h80, 1'b1, 0);
        check("chain_alu_a", 32'(last_alu_a), ACC_EN ? 32'h80 : 32'h11);
        check("chain_y", 32'(last_y), ACC_EN ? 32'h00 : 32'h91);
        check("chain_flags", 32'(last_flags), ACC_EN ? 32'b1011 : 32'b0100);

        // SUB equal operands
        issue(3'd4, 8'h05, 8'h05, 1'b0, 0);
        check("sub_flags", 32'(last_flags), 32'b1010);

        // Backpressure for 5 cycles
        issue(3'd1, 8'hF0, 8'h0F, 1'b0, 5);
        check("bp_y", 32'(last_y), 32'hFF);
        check("bp_flags", 32'(last_flags), 32'b0100);

        // Reset in DONE aborts the operation
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h7F; cmd_b = 8'h01; cmd_use_acc = 1'b0;
        res_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check("abort_pre_res_y", 32'(res_y), 32'h80);
        check("abort_pre_valid", 32'(res_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_values("abort");
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        m_count = 0;
        m_acc = '0;
        step();
        check("abort_post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_post_count", 32'(op_count), 32'd0);

        // Counter wrap: 17 retirements on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            issue(3'd7, 8'h00, 8'($urandom), 1'b0, 0);
            check("wrap_flags", 32'(last_flags), 32'b1000);
        end
        check("wrap_count", 32'(op_count), 32'd1);

        // Random transactions
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/retire stage directly upstream and downstream of the combinational ALU.
- Accepts operation commands on a valid/ready interface and registers the operands and opcode that drive the ALU inputs.
- Captures the ALU result and the four flags one cycle later and presents them on a valid/ready result interface.
- Maintains an accumulator for chained operations and a retired-operation counter.

Parameters:
- W, 8: datapath width; must equal the ALU width.
- COUNT_W, 16: width of the retired-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  ALU opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SHL, 6 SHR, 7 PASS A.
- cmd_a  input  W  operand A.
- cmd_b  input  W  operand B.
- cmd_use_acc  input  1  take operand A from the accumulator instead of cmd_a (see Optional Feature).
- alu_a  output  W  registered operand A to the ALU.
- alu_b  output  W  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_y  input  W  ALU result.
- alu_zero, alu_negative, alu_carry, alu_overflow  input  1 each  ALU flags.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_y  output  W  captured result.
- res_flags  output  4  captured flags {zero, negative, carry, overflow}; bit 3 is zero.
- op_count  output  COUNT_W  number of retired results.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state is IDLE;
  - alu_a, alu_b, alu_op, res_y, res_flags, op_count, and the accumulator are all 0;
  - res_valid is 0.
- Immediately after reset is released, cmd_ready is 1.
- cmd_ready is (state == IDLE) and is driven combinationally from state only, never from cmd_valid.
- IDLE:
  - On cmd_valid && cmd_ready, load alu_a/alu_b/alu_op and go to EXEC.
  - Without cmd_valid, stay in IDLE; alu_* registers hold their last values.
- EXEC:
  - Exactly one cycle, so the ALU settles on the registered inputs.
  - At the next edge, capture alu_y into res_y and the flags into res_flags, set res_valid, update the accumulator to alu_y, and go to DONE.
- DONE:
  - res_valid = 1. res_y and res_flags are stable until the handshake completes.
  - On res_ready, clear res_valid, increment op_count, and return to IDLE.
  - res_ready held low holds DONE indefinitely; cmd_ready stays 0 throughout.
- Timing:
  - Latency is acceptance edge to res_valid high at the next edge: 1 cycle.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, DONE with res_ready=1).
- res_ready asserted while in IDLE or EXEC is ignored.
- op_count wraps modulo 2^COUNT_W with no saturation.
- Width rule: the block performs no arithmetic on the data path; flags are passed through exactly as the ALU produces them.
- Reset asserted in EXEC or DONE aborts the in-flight operation. The result is discarded, op_count is not incremented, and the block returns to the reset state within the same cycle.
- cmd_* changing while the block is not in IDLE has no effect.

Optional Feature:
- Macro: ALU_ISSUE_ACC_EN.
- Defined:
  - The accumulator register exists and is written with alu_y on every EXEC capture.
  - With cmd_use_acc=1 at acceptance, alu_a is loaded from the accumulator and cmd_a is ignored.
- Undefined:
  - No accumulator register is built.
  - cmd_use_acc is ignored; alu_a is always loaded from cmd_a.
  - Port list is unchanged.

Test Plan:
- All tests connect the 8-bit ALU and use W=8.
- ADD overflow: cmd_op=3, A=8'h7F, B=8'h01, res_ready=1. Expect res_valid one cycle after acceptance, res_y=8'h80, res_flags=4'b0101, then op_count=1.
- SUB equal operands: op=4, A=8'h05, B=8'h05. Expect res_y=8'h00, res_flags=4'b1010, since carry=1 means no borrow.
- Backpressure: issue op=1, A=8'hF0, B=8'h0F, with res_ready=0 for 5 cycles. Expect res_valid=1, res_y=8'hFF, res_flags=4'b0100 stable for all 5 cycles and cmd_ready=0. Raise res_ready: one cycle later the state is IDLE and cmd_ready=1.
- Accumulator chain (ALU_ISSUE_ACC_EN defined): run the ADD test first, then cmd_use_acc=1, op=3, cmd_a=8'h11, cmd_b=8'h80. Expect alu_a=8'h80, res_y=8'h00, res_flags=4'b1011. With the macro undefined, expect alu_a=8'h11, res_y=8'h91, res_flags=4'b0100.
- Reset mid-operation: assert rst during DONE with res_y=8'h80. Expect res_valid=0, res_y=0, op_count unchanged at its pre-op value (0 after reset), and cmd_ready=1 after release.
- Counter wrap: with COUNT_W=4, retire 17 operations of op=7, A=8'h00. Expect op_count=1, and res_flags=4'b1000 each time.
